tcdm_bank_responder: RTL and testbench

// Target-side TCDM bank: the responder for one output port of the TCDM interconnect (xbar/bfly/clos).

---
 rtl/tcdm_bank_responder.sv | 112 +++++++++++
 tb/tb_tcdm_bank_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_bank_responder.sv
// Target-side TCDM bank: combinational grant, byte-masked SRAM access, fixed-latency
// load responses, plus programmable post-grant busy time and a stall throttle.
module tcdm_bank_responder #(
  parameter int unsigned AddrMemWidth = 8,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned RespLat      = 1,
  parameter int unsigned BusyCycles   = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [AddrMemWidth-1:0] add_i,
  input  logic                    wen_i,
  input  logic [DataWidth-1:0]    wdata_i,
  input  logic [BeWidth-1:0]      be_i,
  output logic [DataWidth-1:0]    rdata_o,
  output logic                    rvalid_o,
  input  logic                    stall_i,
  output logic                    busy_o
);

  localparam int unsigned Depth  = 2 ** AddrMemWidth;
  localparam int unsigned BusyW  = 8;

  if (RespLat < 1 || RespLat > 8) begin : g_bad_resp_lat
    $fatal(1, "tcdm_bank_responder: RespLat=%0d outside 1..8", RespLat);
  end
  if (BusyCycles > 255) begin : g_bad_busy_cycles
    $fatal(1, "tcdm_bank_responder: BusyCycles=%0d does not fit in 8 bits", BusyCycles);
  end
  if (BeWidth * 8 != DataWidth) begin : g_bad_be_width
    $fatal(1, "tcdm_bank_responder: BeWidth=%0d does not cover DataWidth=%0d", BeWidth, DataWidth);
  end

  logic [BusyW-1:0]     busy_q, busy_d;
  logic                 accept;
  logic                 load_accept;
  logic                 store_accept;

  logic [DataWidth-1:0] mem_q [Depth];

  logic [RespLat-1:0]   valid_q, valid_d;
  logic [DataWidth-1:0] data_q  [RespLat];
  logic [DataWidth-1:0] data_d  [RespLat];

  always_comb begin
    gnt_o        = req_i & ~stall_i & (busy_q == '0) & ~rst_i;
    accept       = req_i & gnt_o;
    load_accept  = accept & ~wen_i;
    store_accept = accept & wen_i;
    busy_o       = (busy_q != '0);
  end

  // Accept and decrement are mutually exclusive because a grant requires an idle counter.
  always_comb begin
    busy_d = busy_q;
    if (accept) begin
      busy_d = BusyW'(BusyCycles);
    end else if (busy_q != '0) begin
      busy_d = busy_q - BusyW'(1);
    end
  end

  // Data only advances alongside a valid token, so the last stage holds the most
  // recent load data between responses.
  always_comb begin
    valid_d    = '0;
    data_d     = data_q;
    valid_d[0] = load_accept;
    if (load_accept) begin
      data_d[0] = mem_q[add_i];
    end
    for (int i = 1; i < int'(RespLat); i++) begin
      valid_d[i] = valid_q[i-1];
      if (valid_q[i-1]) begin
        data_d[i] = data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q  <= '0;
      valid_q <= '0;
      for (int i = 0; i < int'(RespLat); i++) begin
        data_q[i] <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // NOTE: the SRAM array has no reset branch on purpose; contents survive reset and a
  // reset on a memory would also prevent mapping onto a real macro.
  always_ff @(posedge clk_i) begin
    if (store_accept) begin
      for (int b = 0; b < int'(BeWidth); b++) begin
        if (be_i[b]) begin
          mem_q[add_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o  = data_q[RespLat-1];
  assign rvalid_o = valid_q[RespLat-1];

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Directed bench for tcdm_bank_responder: three instances with different latency/busy
// settings share the data inputs; each has its own request line.
module tb_tcdm_bank_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_a, req_b, req_c;
  logic [7:0]  add_i;
  logic        wen_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic        stall_i;

  logic        gnt_a, gnt_b, gnt_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        rvalid_a, rvalid_b, rvalid_c;
  logic        busy_a, busy_b, busy_c;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  tcdm_bank_responder #(.RespLat(1), .BusyCycles(0)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_a), .gnt_o(gnt_a), .add_i(add_i),
    .wen_i(wen_i), .wdata_i(wdata_i), .be_i(be_i), .rdata_o(rdata_a),
    .rvalid_o(rvalid_a), .stall_i(stall_i), .busy_o(busy_a)
  );

  tcdm_bank_responder #(.RespLat(3), .BusyCycles(0)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_b), .gnt_o(gnt_b), .add_i(add_i),
    .wen_i(wen_i), .wdata_i(wdata_i), .be_i(be_i), .rdata_o(rdata_b),
    .rvalid_o(rvalid_b), .stall_i(stall_i), .busy_o(busy_b)
  );

  tcdm_bank_responder #(.RespLat(2), .BusyCycles(2)) dut_c (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_c), .gnt_o(gnt_c), .add_i(add_i),
    .wen_i(wen_i), .wdata_i(wdata_i), .be_i(be_i), .rdata_o(rdata_c),
    .rvalid_o(rvalid_c), .stall_i(stall_i), .busy_o(busy_c)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to 2 time units past the next rising edge; inputs change and outputs are sampled there.
  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic drive(input logic wen, input logic [7:0] add, input logic [31:0] wdata,
                       input logic [3:0] be);
    wen_i   = wen;
    add_i   = add;
    wdata_i = wdata;
    be_i    = be;
    #1;
  endtask

  initial begin
    rst_i   = 1'b1;
    req_a   = 1'b1;
    req_b   = 1'b0;
    req_c   = 1'b0;
    stall_i = 1'b0;
    drive(1'b1, 8'h00, 32'h0, 4'h0);

    // Reset holds grant low even with a request pending.
    check("rst_gnt", 32'(gnt_a), 32'd0);
    check("rst_rvalid", 32'(rvalid_a), 32'd0);
    check("rst_rdata", rdata_a, 32'h0);
    check("rst_busy", 32'(busy_c), 32'd0);
    cyc();
    cyc();
    rst_i = 1'b0;
    #1;
    check("rel_gnt", 32'(gnt_a), 32'd1);

    // Full-word store then partial store, then load back with RespLat=1.
    cyc();
    drive(1'b1, 8'h10, 32'hAABB_CCDD, 4'hF);
    check("st1_gnt", 32'(gnt_a), 32'd1);
    cyc();
    drive(1'b1, 8'h10, 32'h1122_3344, 4'b0101);
    check("st1_no_rvalid", 32'(rvalid_a), 32'd0);
    cyc();
    drive(1'b0, 8'h10, 32'h0, 4'h0);
    check("st2_no_rvalid", 32'(rvalid_a), 32'd0);
    check("ld_gnt", 32'(gnt_a), 32'd1);
    cyc();
    req_a = 1'b0;
    drive(1'b1, 8'h00, 32'h0, 4'h0);
    check("ld_rvalid", 32'(rvalid_a), 32'd1);
    check("ld_rdata", rdata_a, 32'hAA22_CC44);
    cyc();
    check("ld_rvalid_pulse", 32'(rvalid_a), 32'd0);
    check("ld_rdata_hold", rdata_a, 32'hAA22_CC44);
    req_a = 1'b1;
    drive(1'b1, 8'h11, 32'h5555_5555, 4'hF);
    cyc();
    req_a = 1'b0;
    #1;
    check("st_rdata_hold", rdata_a, 32'hAA22_CC44);
    check("st_no_rvalid", 32'(rvalid_a), 32'd0);

    // RespLat=3: preload 1..3, then back-to-back loads.
    req_b = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 8'(i), 32'(i), 4'hF);
      cyc();
    end
    drive(1'b0, 8'h01, 32'h0, 4'h0);
    check("b2b_gnt_t0", 32'(gnt_b), 32'd1);
    cyc();
    drive(1'b0, 8'h02, 32'h0, 4'h0);
    check("b2b_gnt_t1", 32'(gnt_b), 32'd1);
    check("b2b_rvalid_t1", 32'(rvalid_b), 32'd0);
    cyc();
    drive(1'b0, 8'h03, 32'h0, 4'h0);
    check("b2b_gnt_t2", 32'(gnt_b), 32'd1);
    check("b2b_rvalid_t2", 32'(rvalid_b), 32'd0);
    cyc();
    req_b = 1'b0;
    #1;
    check("b2b_rvalid_t3", 32'(rvalid_b), 32'd1);
    check("b2b_rdata_t3", rdata_b, 32'h1);
    cyc();
    check("b2b_rvalid_t4", 32'(rvalid_b), 32'd1);
    check("b2b_rdata_t4", rdata_b, 32'h2);
    cyc();
    check("b2b_rvalid_t5", 32'(rvalid_b), 32'd1);
    check("b2b_rdata_t5", rdata_b, 32'h3);
    cyc();
    check("b2b_rvalid_t6", 32'(rvalid_b), 32'd0);
    check("b2b_rdata_hold", rdata_b, 32'h3);

    // Stall with a load in flight: grant blocked, response on schedule.
    req_b = 1'b1;
    drive(1'b0, 8'h02, 32'h0, 4'h0);
    check("stl_gnt_u0", 32'(gnt_b), 32'd1);
    cyc();
    stall_i = 1'b1;
    drive(1'b1, 8'h00, 32'h0, 4'h0);
    check("stl_gnt_u1", 32'(gnt_b), 32'd0);
    cyc();
    check("stl_gnt_u2", 32'(gnt_b), 32'd0);
    cyc();
    check("stl_gnt_u3", 32'(gnt_b), 32'd0);
    check("stl_rvalid_u3", 32'(rvalid_b), 32'd1);
    check("stl_rdata_u3", rdata_b, 32'h2);
    cyc();
    check("stl_gnt_u4", 32'(gnt_b), 32'd0);
    check("stl_rvalid_u4", 32'(rvalid_b), 32'd0);
    cyc();
    stall_i = 1'b0;
    #1;
    check("stl_gnt_resume", 32'(gnt_b), 32'd1);
    cyc();
    req_b = 1'b0;

    // BusyCycles=2 with request held high: grant 1,0,0,1,0,0.
    req_c = 1'b1;
    drive(1'b1, 8'h00, 32'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("busy_gnt_%0d", k), 32'(gnt_c), (k % 3 == 0) ? 32'd1 : 32'd0);
      check($sformatf("busy_o_%0d", k), 32'(busy_c), (k % 3 == 0) ? 32'd0 : 32'd1);
      cyc();
    end
    req_c = 1'b0;
    cyc();

    // Store, load, then reset before the response: response dropped, data retained.
    req_c = 1'b1;
    drive(1'b1, 8'h20, 32'hDEAD_BEEF, 4'hF);
    check("rs_st_gnt", 32'(gnt_c), 32'd1);
    cyc();
    req_c = 1'b0;
    cyc();
    cyc();
    req_c = 1'b1;
    drive(1'b0, 8'h20, 32'h0, 4'h0);
    check("rs_ld_gnt", 32'(gnt_c), 32'd1);
    cyc();
    req_c = 1'b0;
    rst_i = 1'b1;
    #1;
    check("rs_rvalid_in_rst", 32'(rvalid_c), 32'd0);
    cyc();
    rst_i = 1'b0;
    #1;
    check("rs_rvalid_dropped", 32'(rvalid_c), 32'd0);
    check("rs_busy_cleared", 32'(busy_c), 32'd0);
    cyc();
    check("rs_rvalid_after", 32'(rvalid_c), 32'd0);
    check("rs_rdata_cleared", rdata_c, 32'h0);
    req_c = 1'b1;
    drive(1'b0, 8'h20, 32'h0, 4'h0);
    check("rs_reload_gnt", 32'(gnt_c), 32'd1);
    cyc();
    req_c = 1'b0;
    #1;
    check("rs_reload_rvalid_early", 32'(rvalid_c), 32'd0);
    cyc();
    check("rs_reload_rvalid", 32'(rvalid_c), 32'd1);
    check("rs_reload_rdata", rdata_c, 32'hDEAD_BEEF);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
